// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART definitions: data width, register map offsets and status-bit layout
// used by the TX buffer and the register bank that reads its status.
package uart_tx_buffer_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [7:0] REG_TX_DATA = 8'h00;
  localparam logic [7:0] REG_RX_DATA = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] REG_CONTROL = 8'h0C;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_AF_BIT    = 2;
  localparam int STAT_OVF_BIT   = 3;

  // Field order matches the status-bit positions above (empty at bit 0).
  typedef struct packed {
    logic overflow;
    logic almost_full;
    logic full;
    logic empty;
  } tx_status_t;

  function automatic tx_status_t make_status(input logic is_empty, input logic is_full,
                                             input logic is_af, input logic is_ovf);
    tx_status_t s;
    s.empty       = is_empty;
    s.full        = is_full;
    s.almost_full = is_af;
    s.overflow    = is_ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_buffer.sv
// Byte FIFO between the UART TX data register and the serializer: valid/ready
// output handshake, registered fill level, sticky overflow and a handshake counter.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [UART_DATA_W-1:0]   wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  input  logic                     clear_ovf,
  output logic [UART_DATA_W-1:0]   tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_data_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [15:0]              tx_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);

  logic [UART_DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic [LW-1:0]          level_nxt_s;
  logic [15:0]            tx_count_r;
  logic                   overflow_r;
  logic                   overflow_nxt_s;
  logic                   full_s;
  logic                   valid_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   ovf_set_s;
  tx_status_t             status_s;

  // Handshake qualification; flush suppresses both sides and any overflow event.
  always_comb begin
    full_s    = (level_r == DEPTH_L);
    valid_s   = (level_r != {LW{1'b0}});
    push_s    = wr_valid && !full_s && !flush;
    pop_s     = valid_s && tx_data_ready && !flush;
    ovf_set_s = wr_valid && full_s && !flush;
  end

  // Next fill level and next sticky overflow value.
  always_comb begin
    level_nxt_s    = level_r;
    overflow_nxt_s = overflow_r;
    if (flush) begin
      level_nxt_s = {LW{1'b0}};
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + LW'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LW'(1);
    end else begin
      level_nxt_s = level_r;
    end
    if (ovf_set_s) begin
      overflow_nxt_s = 1'b1;
    end else if (clear_ovf) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, level, overflow flag and handshake counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
      tx_count_r <= 16'h0000;
    end else begin
      level_r    <= level_nxt_s;
      overflow_r <= overflow_nxt_s;
      if (flush) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r   <= rd_ptr_r + PW'(1);
          tx_count_r <= tx_count_r + 16'd1;
        end
      end
    end
  end

  assign status_s = make_status(!valid_s, full_s, (level_r >= AF_L), overflow_r);

  assign tx_data       = valid_s ? mem_r[rd_ptr_r] : {UART_DATA_W{1'b0}};
  assign tx_data_valid = valid_s;
  assign wr_ready      = !status_s.full;
  assign level         = level_r;
  assign empty         = status_s.empty;
  assign full          = status_s.full;
  assign almost_full   = status_s.almost_full;
  assign overflow      = status_s.overflow;
  assign tx_count      = tx_count_r;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a byte scoreboard queue plus a small
// level/overflow/count model, checked with immediate assertions.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        flush;
  logic        clear_ovf;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic [15:0] tx_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  int          m_level  = 0;
  logic        m_ovf    = 1'b0;
  logic [15:0] m_count  = 16'h0000;

  uart_tx_buffer #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .flush(flush), .clear_ovf(clear_ovf), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .level(level),
    .empty(empty), .full(full), .almost_full(almost_full), .overflow(overflow),
    .tx_count(tx_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".level"},       32'(level),         32'(m_level));
    chk({tag, ".empty"},       32'(empty),         32'(m_level == 0));
    chk({tag, ".full"},        32'(full),          32'(m_level == DEPTH));
    chk({tag, ".wr_ready"},    32'(wr_ready),      32'(m_level != DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full),   32'(m_level >= AF));
    chk({tag, ".valid"},       32'(tx_data_valid), 32'(m_level != 0));
    chk({tag, ".tx_data"},     32'(tx_data),       32'((m_level != 0) ? exp_q[0] : 8'h00));
    chk({tag, ".overflow"},    32'(overflow),      32'(m_ovf));
    chk({tag, ".tx_count"},    32'(tx_count),      32'(m_count));
  endtask

  // Drive one cycle of inputs at the falling edge, update the model, advance.
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rdy,
                       input logic fl, input logic clr);
    logic do_push;
    logic do_pop;
    wr_valid = wv; wr_data = wd; tx_data_ready = rdy; flush = fl; clear_ovf = clr;
    do_push = wv && (m_level != DEPTH) && !fl;
    do_pop  = (m_level != 0) && rdy && !fl;
    if (do_pop) begin
      chk("pop_data", 32'(tx_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (do_push) exp_q.push_back(wd);
    if (fl) begin
      exp_q.delete();
      m_level = 0;
    end else begin
      m_level = m_level + int'(do_push) - int'(do_pop);
    end
    if (wv && (m_level == DEPTH) && !do_pop && !do_push && !fl) m_ovf = 1'b1;
    else if (wv && !do_push && !fl) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk_in);
    wr_valid = 1'b0; tx_data_ready = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
    clear_ovf = 1'b0; tx_data_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    check_status("reset_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    check_status("idle");

    // Single byte: one-cycle latency, stable while stalled, then one handshake.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_status("first_write");
    chk("first_write.literal", 32'(tx_data), 32'h0000_00A5);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("stall_stable", 32'(tx_data), 32'h0000_00A5);
      chk("stall_valid", 32'(tx_data_valid), 32'h1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_status("single_pop");
    chk("single_pop.count", 32'(tx_count), 32'h1);

    // Fill to full, overflow on the 17th, then dropped write during a pop.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check_status("fill");
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_status("overflow_write");
    chk("overflow_write.literal", 32'(overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_status("clear_ovf");
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    check_status("full_write_with_pop");
    for (int k = 0; k < DEPTH + 2 && exp_q.size() > 0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_status("drained");
    chk("drained.count", 32'(tx_count), 32'd17);

    // Steady push+pop at level 3, wrapping the pointers.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
    check_status("stream_level3");

    // Flush with concurrent write and handshake at level 5; overflow is set.
    cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_status("pre_flush");
    chk("pre_flush.level5", 32'(level), 32'd5);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check_status("flush");
    chk("flush.valid", 32'(tx_data_valid), 32'h0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    check_status("set_beats_clear");
    chk("set_beats_clear.literal", 32'(overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_status("flush_empty");

    // Run tx_count up to 16'hFFFF and across the wrap.
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    begin
      int n_hs;
      n_hs = 32'hFFFF - 32'(m_count);
      for (int i = 0; i < n_hs; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    end
    chk("count_max", 32'(tx_count), 32'h0000_FFFF);
    cycle(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
    chk("count_wrap", 32'(tx_count), 32'h0000_0001);
    check_status("after_wrap");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_data = 8'hDD; tx_data_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); m_level = 0; m_ovf = 1'b0; m_count = 16'h0000;
    check_status("async_reset");
    wr_valid = 1'b0; tx_data_ready = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check_status("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
